// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - boot loader: byte stream to 16-bit instruction memory writes
// Holds the CPU in reset until a length-prefixed program has been fully written.
module instruction_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] imem_address,
  output logic [15:0] imem_data,
  output logic        imem_wren,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  word_hi_q, word_hi_d;
  logic [15:0] words_loaded_q, words_loaded_d;
  logic [15:0] imem_address_q, imem_address_d;
  logic [15:0] imem_data_q, imem_data_d;
  logic        imem_wren_q, imem_wren_d;
  logic        byte_ready_q, byte_ready_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [15:0] full_len;
  logic [15:0] next_loaded;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    word_hi_d      = word_hi_q;
    words_loaded_d = words_loaded_q;
    imem_address_d = imem_address_q;
    imem_data_d    = imem_data_q;
    accept         = byte_valid && byte_ready_q;
    full_len       = {count_q[15:8], byte_in};
    next_loaded    = words_loaded_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          count_d[15:8] = byte_in;
          state_d       = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_d = full_len;
          if (full_len == 16'd0 || full_len > MAX_LEN) state_d = S_ERROR;
          else                                         state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          word_hi_d = byte_in;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          imem_data_d    = {word_hi_q, byte_in};
          imem_address_d = words_loaded_q;
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        words_loaded_d = next_loaded;
        if (next_loaded == count_q) state_d = S_DONE;
        else                        state_d = S_DATA_HI;
      end
      S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase

    // A new session starts with a clean count; LEN_HI is only entered from idle-like states.
    if (state_d == S_LEN_HI && state_q != S_LEN_HI) words_loaded_d = 16'd0;

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA_HI) || (state_d == S_DATA_LO);
    imem_wren_d  = (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    cpu_reset_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      count_q        <= 16'd0;
      word_hi_q      <= 8'd0;
      words_loaded_q <= 16'd0;
      imem_address_q <= 16'd0;
      imem_data_q    <= 16'd0;
      imem_wren_q    <= 1'b0;
      byte_ready_q   <= 1'b0;
      cpu_reset_q    <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      word_hi_q      <= word_hi_d;
      words_loaded_q <= words_loaded_d;
      imem_address_q <= imem_address_d;
      imem_data_q    <= imem_data_d;
      imem_wren_q    <= imem_wren_d;
      byte_ready_q   <= byte_ready_d;
      cpu_reset_q    <= cpu_reset_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_address = imem_address_q;
  assign imem_data    = imem_data_q;
  assign imem_wren    = imem_wren_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
// Expected writes and status are derived from the byte stream itself.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] imem_address;
  logic [15:0] imem_data;
  logic        imem_wren;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  instruction_loader #(.MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_address (imem_address),
    .imem_data    (imem_data),
    .imem_wren    (imem_wren),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  always @(negedge clk) begin
    if (imem_wren === 1'b1) begin
      wa.push_back(imem_address);
      wd.push_back(imem_data);
      wc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] stream[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_imem_wren"}, 32'(imem_wren), 32'd0);
    check({tag, "_imem_address"}, 32'(imem_address), 32'd0);
    check({tag, "_imem_data"}, 32'(imem_data), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic build_stream(input logic [15:0] len_hdr, input int nwords);
    stream.delete();
    stream.push_back(len_hdr[15:8]);
    stream.push_back(len_hdr[7:0]);
    for (int i = 0; i < 2 * nwords; i++) stream.push_back(8'($urandom));
  endtask

  // Called at a negedge; returns at the negedge following the final accepting edge.
  task automatic send_bytes(input int upto, input int gap_max);
    int n;
    for (int i = 0; i < upto; i++) begin
      if (gap_max > 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(gap_max, 1)) @(negedge clk);
      end
      byte_in    = stream[i];
      byte_valid = 1'b1;
      n = 0;
      while (byte_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("ready_wait", 32'(n < 100), 32'd1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input int gap_max);
    logic [15:0] len;
    logic        exp_err;
    int          exp_n;
    int          consumed;
    int          n;
    int          done_cyc;
    int          last_wc;
    len      = {stream[0], stream[1]};
    exp_err  = (len == 16'd0) || (len > 16'd256);
    exp_n    = exp_err ? 0 : int'(len);
    consumed = 2 + 2 * exp_n;
    wa.delete();
    wd.delete();
    wc.delete();
    start_pulse();
    check("start_byte_ready", 32'(byte_ready), 32'd1);
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
    check("start_words_loaded", 32'(words_loaded), 32'd0);
    send_bytes(consumed, gap_max);
    if (exp_err) begin
      check("err_next_cycle", 32'(error), 32'd1);
      check("err_cpu_reset", 32'(cpu_reset), 32'd1);
      repeat (4) @(negedge clk);
      check("err_no_writes", 32'(wa.size()), 32'd0);
      check("err_held", 32'(error), 32'd1);
      check("err_done", 32'(done), 32'd0);
      check("err_byte_ready", 32'(byte_ready), 32'd0);
    end else begin
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      done_cyc = cyc;
      check("done_seen", 32'(n < 20), 32'd1);
      last_wc = (wc.size() > 0) ? wc[wc.size() - 1] : -100;
      check("done_after_last_write", 32'(done_cyc), 32'(last_wc + 1));
      repeat (4) @(negedge clk);
      check("write_count", 32'(wa.size()), 32'(exp_n));
      for (int i = 0; i < wa.size() && i < exp_n; i++) begin
        check("write_addr", 32'(wa[i]), 32'(i));
        check("write_data", 32'(wd[i]), 32'({stream[2 + 2 * i], stream[3 + 2 * i]}));
        if (gap_max == 0 && i > 0) check("write_spacing", 32'(wc[i] - wc[i - 1]), 32'd3);
      end
      check("fin_cpu_reset", 32'(cpu_reset), 32'd0);
      check("fin_done", 32'(done), 32'd1);
      check("fin_error", 32'(error), 32'd0);
      check("fin_words_loaded", 32'(words_loaded), 32'(exp_n));
      check("fin_byte_ready", 32'(byte_ready), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_byte_ready", 32'(byte_ready), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    stream = '{8'h00, 8'h03, 8'h11, 8'h23, 8'h24, 8'h56, 8'h37, 8'h89};
    run_session(0);
    if (wd.size() == 3) begin
      check("fixed_d0", 32'(wd[0]), 32'h1123);
      check("fixed_d1", 32'(wd[1]), 32'h2456);
      check("fixed_d2", 32'(wd[2]), 32'h3789);
    end

    // Reload from DONE with stalls between bytes.
    run_session(4);

    build_stream(16'd5, 5);
    run_session(2);

    build_stream(16'd0, 0);
    run_session(0);
    build_stream(16'd1, 1);
    run_session(0);

    build_stream(16'h0101, 0);
    run_session(0);
    build_stream(16'h0100, 256);
    run_session(0);

    // Abort mid-load; reset asserted together with start must win.
    build_stream(16'd4, 4);
    wa.delete();
    wd.delete();
    wc.delete();
    start_pulse();
    send_bytes(4, 0);
    repeat (2) @(negedge clk);
    check("abort_one_write", 32'(wa.size()), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("after_rst_byte_ready", 32'(byte_ready), 32'd0);
    check("after_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    run_session(0);

    build_stream(16'(($urandom_range(12, 2))), 12);
    run_session(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that writes the instruction memory the fetch stage reads from. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first), and writes them to consecutive instruction-memory addresses starting at 0. While loading, it holds the CPU pipeline in reset, and it releases the CPU once the whole program has been written. It sits between the external load port and the write side of the instruction memory.

## Interface
Parameters:
- MAX_WORDS, 256, largest accepted program length in words (must be ≤ 65535)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  begin a load session (sampled in IDLE, DONE, ERROR only)
- byte_in  in  8  incoming stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader can accept a byte this cycle
- imem_address  out  16  instruction-memory write address (word index)
- imem_data  out  16  instruction word to write
- imem_wren  out  1  instruction-memory write strobe, one cycle per word
- cpu_reset  out  1  drives pipeline reset; high whenever the program is not fully loaded
- done  out  1  program loaded, CPU released
- error  out  1  length header rejected
- words_loaded  out  16  count of words written this session

## Operation
- Stream format: LEN_HI, LEN_LO (word count N), then N words as HI byte, LO byte.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
- IDLE: start=1 → LEN_HI.
- LEN_HI: on accept, latch count[15:8] → LEN_LO.
- LEN_LO: on accept, latch count[7:0]. If full count = 0 or > MAX_WORDS → ERROR; else → DATA_HI.
- DATA_HI: on accept, latch word[15:8] → DATA_LO.
- DATA_LO: on accept, latch word[7:0] → WRITE.
- WRITE: imem_wren=1, imem_address=words_loaded, imem_data=assembled word. Then words_loaded += 1. If the new value equals count → DONE; else → DATA_HI.
- DONE: done=1, cpu_reset=0. start=1 → LEN_HI (reload).
- ERROR: error=1, cpu_reset=1. start=1 → LEN_HI.
- Entering LEN_HI from any state clears words_loaded, done and error and sets cpu_reset=1.
- byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO. Bytes presented in any other state are not consumed.
- start is ignored in LEN_*, DATA_* and WRITE states.
- Bytes after the Nth word are not consumed; the source must not rely on them.
- Arithmetic: words_loaded is 16-bit. The length comparison uses the full 16-bit count, so no wrap is possible because MAX_WORDS ≤ 65535.

## Timing
- All outputs are registered.
- Reset values: byte_ready=0, imem_wren=0, imem_address=0, imem_data=0, cpu_reset=1, done=0, error=0, words_loaded=0. State = IDLE.
- Reset asserted mid-load aborts immediately. Words already written stay in memory but the session is discarded; cpu_reset stays 1.
- start in IDLE → byte_ready=1 on the next cycle.
- Throughput: minimum 3 cycles per word (two accept cycles plus one WRITE cycle). byte_ready=0 during WRITE.
- imem_wren is high exactly 1 cycle per word. imem_address/imem_data are valid in that same cycle.
- done=1 and cpu_reset=0 are asserted together, the cycle after the final WRITE cycle.
- error=1 is asserted the cycle after the LEN_LO byte is accepted; no write occurs.
- byte_valid may drop for any number of cycles in any accepting state. The state holds and no write occurs.
- start asserted together with reset: reset wins.

## Test plan
- Reset, start, send 00 03 11 23 24 56 37 89 back-to-back → three imem_wren pulses:
  - addr 0 / 0x1123, addr 1 / 0x2456, addr 2 / 0x3789, each 3 cycles apart.
  - done=1 and cpu_reset=0 one cycle after the third write; words_loaded=3.
- Same stream with byte_valid low 1–4 random cycles between bytes → identical writes and final state, no extra imem_wren pulses.
- Length 00 00 → error=1 one cycle after LEN_LO, cpu_reset stays 1, no imem_wren. Then start plus a valid 1-word stream → done=1, error=0.
- Length 01 01 (257 > MAX_WORDS=256) → error=1, no writes. Length 01 00 (256) → accepted, 256 writes at addresses 0..255, then done=1.
- Send length 00 04 and one word, then assert reset → all outputs at reset values the next cycle. A new start plus full stream writes again from address 0.
- In DONE, pulse start → the next cycle has cpu_reset=1, done=0, words_loaded=0, byte_ready=1; the reload completes normally.
